// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: reloads the SoC instruction ROM from a byte stream.
// Stream: 4-byte little-endian word count N, N little-endian 32-bit words,
// then one checksum byte (low 8 bits of the sum of all payload bytes).
// The core is held in reset while a load is in progress or has failed.
module imem_load_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        byte_ready_o,
  output logic        wen_o,
  output logic        ren_o,
  output logic [31:0] w_addr_o,
  output logic [31:0] w_data_o,
  output logic        cpu_hold_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [31:0]     DEPTH_L = 32'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LOAD = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nx;

  // datapath registers
  logic [23:0]       hdr_buf;      // upper bytes of the header collected so far
  logic [31:0]       n_words;      // word count taken from the header
  logic [23:0]       word_buf;     // upper bytes of the payload word in progress
  logic [1:0]        byte_cnt;     // byte position within header / word
  logic [31:0]       idx;          // index of the next word to be written
  logic [7:0]        sum;          // running payload checksum, wraps mod 256
  logic [TO_W-1:0]   to_cnt;       // idle cycles since last accepted byte

  // combinational helpers
  logic              accept;
  logic              busy_state;
  logic              last_byte;
  logic              last_word;
  logic              hdr_bad;
  logic              timeout_hit;
  logic              entering;
  logic [31:0]       hdr_full;
  logic [31:0]       word_full;

  // registered-output next values
  logic              ready_nx;
  logic              ren_nx;
  logic              hold_nx;
  logic              busy_nx;
  logic              done_nx;
  logic              err_nx;
  logic              wen_nx;
  logic [31:0]       addr_nx;
  logic [31:0]       data_nx;

  // byte_ready_o is a register that is 1 exactly in HDR/LOAD/CHK, so the
  // handshake never depends combinationally on byte_valid_i.
  assign accept      = byte_valid_i & byte_ready_o;
  assign busy_state  = (state == S_HDR) || (state == S_LOAD) || (state == S_CHK);
  assign last_byte   = (byte_cnt == 2'd3);
  assign last_word   = (idx == (n_words - 32'd1));
  assign hdr_full    = {byte_i, hdr_buf};
  assign word_full   = {byte_i, word_buf};
  assign hdr_bad     = (hdr_full == 32'd0) || (hdr_full > DEPTH_L);
  assign timeout_hit = busy_state && !accept && (to_cnt == TO_LAST);
  assign entering    = (state_nx != state);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_nx = S_HDR;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_HDR: begin
        if (accept && last_byte) begin
          if (hdr_bad) begin
            state_nx = S_ERR;
          end else begin
            state_nx = S_LOAD;
          end
        end else if (timeout_hit) begin
          state_nx = S_ERR;
        end else begin
          state_nx = S_HDR;
        end
      end
      S_LOAD: begin
        if (accept && last_byte && last_word) begin
          state_nx = S_CHK;
        end else if (timeout_hit) begin
          state_nx = S_ERR;
        end else begin
          state_nx = S_LOAD;
        end
      end
      S_CHK: begin
        if (accept) begin
          if (byte_i == sum) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_ERR;
          end
        end else if (timeout_hit) begin
          state_nx = S_ERR;
        end else begin
          state_nx = S_CHK;
        end
      end
      S_DONE: begin
        if (start_i) begin
          state_nx = S_HDR;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_ERR: begin
        if (start_i) begin
          state_nx = S_HDR;
        end else begin
          state_nx = S_ERR;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state
  always_comb begin
    ready_nx = 1'b0;
    ren_nx   = 1'b1;
    hold_nx  = 1'b0;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    wen_nx   = 1'b0;
    addr_nx  = w_addr_o;
    data_nx  = w_data_o;
    case (state_nx)
      S_IDLE: begin
        ren_nx = 1'b1;
      end
      S_HDR, S_LOAD, S_CHK: begin
        ready_nx = 1'b1;
        ren_nx   = 1'b0;
        hold_nx  = 1'b1;
        busy_nx  = 1'b1;
      end
      S_DONE: begin
        done_nx = 1'b1;
      end
      S_ERR: begin
        ren_nx  = 1'b0;
        hold_nx = 1'b1;
        err_nx  = 1'b1;
      end
      default: begin
        ren_nx = 1'b1;
      end
    endcase
    // a completed word is written in the cycle after its last byte
    if ((state == S_LOAD) && accept && last_byte) begin
      wen_nx  = 1'b1;
      addr_nx = BASE_ADDR + (idx << 2);
      data_nx = word_full;
    end else begin
      wen_nx  = 1'b0;
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_ready_o <= 1'b0;
      wen_o        <= 1'b0;
      ren_o        <= 1'b1;
      w_addr_o     <= 32'h0;
      w_data_o     <= 32'h0;
      cpu_hold_o   <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      byte_ready_o <= ready_nx;
      wen_o        <= wen_nx;
      ren_o        <= ren_nx;
      w_addr_o     <= addr_nx;
      w_data_o     <= data_nx;
      cpu_hold_o   <= hold_nx;
      busy_o       <= busy_nx;
      done_o       <= done_nx;
      err_o        <= err_nx;
    end
  end

  // Header/payload collection, word index, checksum and idle timer
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_buf  <= 24'h0;
      n_words  <= 32'h0;
      word_buf <= 24'h0;
      byte_cnt <= 2'd0;
      idx      <= 32'h0;
      sum      <= 8'h0;
      to_cnt   <= '0;
    end else begin
      if ((state_nx == S_HDR) && (state != S_HDR)) begin
        // fresh load: forget everything from the previous attempt
        byte_cnt <= 2'd0;
        idx      <= 32'h0;
        sum      <= 8'h0;
      end else if (accept && (state == S_HDR)) begin
        hdr_buf  <= hdr_full[31:8];
        byte_cnt <= byte_cnt + 2'd1;
        if (last_byte) begin
          n_words <= hdr_full;
        end else begin
          n_words <= n_words;
        end
      end else if (accept && (state == S_LOAD)) begin
        word_buf <= word_full[31:8];
        byte_cnt <= byte_cnt + 2'd1;
        sum      <= sum + byte_i;
        if (last_byte) begin
          idx <= idx + 32'd1;
        end else begin
          idx <= idx;
        end
      end else begin
        byte_cnt <= byte_cnt;
      end

      if (entering || accept || !busy_state) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl (DEPTH_WORDS=4, TIMEOUT_CYC=16).
module tb_imem_load_ctrl;

  localparam logic [31:0] BASE  = 32'h0;
  localparam int          DEPTH = 4;
  localparam int          TOC   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_in = 8'h0;
  logic        byte_ready, wen, ren, cpu_hold, busy, done, err;
  logic [31:0] w_addr, w_data;

  imem_load_ctrl #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .TIMEOUT_CYC(TOC)) dut (
    .clk(clk), .rst(rst), .start_i(start), .byte_valid_i(byte_valid), .byte_i(byte_in),
    .byte_ready_o(byte_ready), .wen_o(wen), .ren_o(ren), .w_addr_o(w_addr), .w_data_o(w_data),
    .cpu_hold_o(cpu_hold), .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int stall_cnt = 0;
  logic [63:0] wr_q[$];    // observed writes {addr, data}
  logic [63:0] exp_q[$];   // model writes
  logic [7:0]  pay_q[$];   // byte stream to send

  typedef struct {
    logic [31:0] n;
    logic [31:0] seed;
    bit          bad;
    bit          exp_done;
    bit          exp_err;
    int          exp_nw;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // write/done monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (wen) begin
      wr_q.push_back({w_addr, w_data});
      check("wen_excl_ren", {31'h0, ren}, 32'h0);
      check("hold_during_wen", {31'h0, cpu_hold}, 32'h1);
    end
    if (done) done_cnt++;
  end

  function automatic bit hdr_ok(input logic [31:0] n);
    return (n != 32'h0) && (n <= 32'(DEPTH));
  endfunction

  task automatic start_pulse();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    repeat (gap) begin @(negedge clk); byte_valid = 1'b0; end
    @(negedge clk); byte_valid = 1'b1; byte_in = b;
    waited = 0;
    while (!byte_ready && waited < 40) begin
      @(negedge clk); waited++; stall_cnt++;
    end
    check("byte_accept", {31'h0, byte_ready}, 32'h1);
    if (byte_ready) @(posedge clk);
    else byte_valid = 1'b0;
  endtask

  task automatic send_all(input int maxgap);
    foreach (pay_q[i]) send_byte(pay_q[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
  endtask

  task automatic end_stream();
    @(negedge clk); byte_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_obs();
    wr_q.delete(); exp_q.delete(); pay_q.delete();
    done_cnt = 0; stall_cnt = 0;
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwrites"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < wr_q.size()) begin
        check({tag, "_addr"}, wr_q[i][63:32], exp_q[i][63:32]);
        check({tag, "_data"}, wr_q[i][31:0], exp_q[i][31:0]);
      end
    end
  endtask

  // Reference model: builds the stream and the expected writes from N, seed, bad
  task automatic run_load(input logic [31:0] n, input logic [31:0] seed, input bit bad,
                          input bit exp_done, input bit exp_err, input int exp_nw,
                          input int maxgap, input string tag);
    int s;
    logic [31:0] w;
    clear_obs();
    for (int k = 0; k < 4; k++) pay_q.push_back(8'((n >> (8 * k)) & 32'hFF));
    if (hdr_ok(n)) begin
      s = 0;
      for (int i = 0; i < int'(n); i++) begin
        w = seed + 32'(i) * 32'h3C6EF35F;
        exp_q.push_back({BASE + 32'(4 * i), w});
        for (int k = 0; k < 4; k++) begin
          pay_q.push_back(8'((w >> (8 * k)) & 32'hFF));
          s = (s + int'((w >> (8 * k)) & 32'hFF)) % 256;
        end
      end
      pay_q.push_back(bad ? 8'(s ^ 1) : 8'(s));
    end
    start_pulse();
    check({tag, "_busy_start"}, {31'h0, busy}, 32'h1);
    check({tag, "_err_cleared"}, {31'h0, err}, 32'h0);
    send_all(maxgap);
    end_stream();
    check({tag, "_done_cnt"}, done_cnt, exp_done ? 32'd1 : 32'd0);
    check({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
    check({tag, "_ren"}, {31'h0, ren}, {31'h0, !exp_err});
    check({tag, "_hold"}, {31'h0, cpu_hold}, {31'h0, exp_err});
    check({tag, "_busy_end"}, {31'h0, busy}, 32'h0);
    check({tag, "_nw_table"}, exp_q.size(), exp_nw);
    check_writes(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] n;
    bit bad;
    vecs[0] = '{n: 32'd1, seed: 32'hDEADBEEF, bad: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_nw: 1};
    vecs[1] = '{n: 32'd4, seed: 32'h01020304, bad: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_nw: 4};
    vecs[2] = '{n: 32'd0, seed: 32'h0,        bad: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_nw: 0};
    vecs[3] = '{n: 32'd5, seed: 32'h0,        bad: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_nw: 0};
    vecs[4] = '{n: 32'h01000002, seed: 32'h0, bad: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_nw: 0};
    vecs[5] = '{n: 32'd3, seed: 32'h55AA00FF, bad: 1'b1, exp_done: 1'b0, exp_err: 1'b1, exp_nw: 3};
    vecs[6] = '{n: 32'd2, seed: 32'hFFFFFFFF, bad: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_nw: 2};

    // 1: reset then idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_ren", {31'h0, ren}, 32'h1);
    check("idle_hold", {31'h0, cpu_hold}, 32'h0);
    check("idle_wen", {31'h0, wen}, 32'h0);
    check("idle_ready", {31'h0, byte_ready}, 32'h0);
    check("idle_err", {31'h0, err}, 32'h0);

    // 2: fixed normal load
    clear_obs();
    pay_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
    exp_q = '{{32'h0, 32'h00000013}, {32'h4, 32'h0000006F}};
    start_pulse();
    send_all(0);
    end_stream();
    check("fixed_done", done_cnt, 32'd1);
    check("fixed_ren", {31'h0, ren}, 32'h1);
    check("fixed_hold", {31'h0, cpu_hold}, 32'h0);
    check_writes("fixed");

    // 3: bad checksum, then start clears the error
    clear_obs();
    pay_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h83};
    exp_q = '{{32'h0, 32'h00000013}, {32'h4, 32'h0000006F}};
    start_pulse();
    send_all(1);
    end_stream();
    check("badchk_done", done_cnt, 32'd0);
    check("badchk_err", {31'h0, err}, 32'h1);
    check("badchk_hold", {31'h0, cpu_hold}, 32'h1);
    check("badchk_ren", {31'h0, ren}, 32'h0);
    check_writes("badchk");
    start_pulse();
    check("restart_err", {31'h0, err}, 32'h0);
    check("restart_busy", {31'h0, busy}, 32'h1);
    check("restart_ready", {31'h0, byte_ready}, 32'h1);
    clear_obs();
    pay_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_all(0);
    end_stream();
    check("n0_err", {31'h0, err}, 32'h1);
    check_writes("n0");

    // table-driven loads
    foreach (vecs[i])
      run_load(vecs[i].n, vecs[i].seed, vecs[i].bad, vecs[i].exp_done, vecs[i].exp_err,
               vecs[i].exp_nw, 2, $sformatf("vec%0d", i));

    // 5: back-to-back bytes, N=3
    run_load(32'd3, 32'h00C0FFEE, 1'b0, 1'b1, 1'b0, 3, 0, "b2b");
    check("b2b_stalls", stall_cnt, 32'd0);

    // randomized loads against the model
    for (int r = 0; r < 20; r++) begin
      n = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 32'd0 : 32'(DEPTH + 1)) :
          32'($urandom_range(1, DEPTH));
      bad = ($urandom_range(0, 3) == 0);
      run_load(n, $urandom, bad, hdr_ok(n) && !bad, !(hdr_ok(n) && !bad),
               hdr_ok(n) ? int'(n) : 0, 3, $sformatf("rnd%0d", r));
    end

    // 6a: timeout after two payload bytes
    clear_obs();
    pay_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
    start_pulse();
    send_all(0);
    @(negedge clk); byte_valid = 1'b0;
    repeat (TOC - 1) @(negedge clk);
    check("to_before_err", {31'h0, err}, 32'h0);
    check("to_before_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    check("to_err", {31'h0, err}, 32'h1);
    check("to_hold", {31'h0, cpu_hold}, 32'h1);
    check("to_nwrites", wr_q.size(), 32'd0);

    // 6b: reset during LOAD
    clear_obs();
    pay_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    start_pulse();
    send_all(0);
    @(negedge clk); byte_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_ren", {31'h0, ren}, 32'h1);
    check("rst_hold", {31'h0, cpu_hold}, 32'h0);
    check("rst_wen", {31'h0, wen}, 32'h0);
    check("rst_ready", {31'h0, byte_ready}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_addr", w_addr, 32'h0);
    check("rst_data", w_data, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
